priority_encoder_8x3: RTL and testbench
=======================================

Name: priority_encoder_8x3

Overview:
- Registered 8-to-3 priority encoder with enable.
- Reports the index of the most-significant asserted bit of an 8-bit request vector, plus valid and multi-hot flags.
- Sits between request-generating logic (interrupt/arbitration sources) and downstream consumers that need a binary index.
- Outputs are registered: one clock of latency from input sample to output.

Parameters:
- HOLD_WHEN_DISABLED, default 0: 0 = outputs clear to zero while en=0; 1 = outputs hold their last value while en=0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
- en  input  1  encoder enable.
- in  input  8  request vector; bit 7 has highest priority, bit 0 lowest.
- out  output  3  binary index of the highest-priority set bit (registered).
- valid  output  1  high when en was 1 and at least one bit of in was set (registered).
- multi  output  1  high when en was 1 and more than one bit of in was set (registered).

Behaviour:
- Reset: on a rising clk edge with rst_n=0, out=3'd0, valid=0, multi=0. Reset overrides en and in.
- Latency: in and en are sampled on rising clk edge N; the results appear on out, valid and multi after edge N and hold until the next edge.
- Priority:
  - out equals the position of the most-significant 1 in in. 1xxxxxxx -> 7, 01xxxxxx -> 6, ..., 00000001 -> 0.
  - Bits below the leading 1 are don't-care, including X/Z. out and valid must not be corrupted by unknown values below the leading 1.
  - Implement with priority-ordered or casez-style decoding, not arithmetic.
- in = 8'h00 with en=1: out=0, valid=0, multi=0. valid distinguishes this case from in=8'h01.
- multi:
  - Set when two or more bits of in are 1.
  - Defined only for fully known inputs. With X below the leading 1, multi may be X; out and valid stay correct.
- en=0 with HOLD_WHEN_DISABLED=0: on the next edge out=0, valid=0, multi=0, regardless of in.
- en=0 with HOLD_WHEN_DISABLED=1: all three outputs keep their previous registered values.
- Re-enable: the first edge with en=1 after a disabled period produces the encoding of the current in. No extra latency and no stale data.
- No combinational path from inputs to outputs.
- No internal state besides the three output registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1, in=8'hFF -> out=0, valid=0, multi=0. Release rst_n -> after the next edge out=7, valid=1, multi=1.
- Disabled: en=0, in=8'b00000001 -> out=0, valid=0 (HOLD_WHEN_DISABLED=0). Then en=1 with the same in -> one edge later out=0, valid=1, multi=0.
- Priority walk with en=1, one edge per vector, lower bits X:
  - 00000001->0, 0000001x->1, 000001xx->2, 00001xxx->3
  - 0001xxxx->4, 001xxxxx->5, 01xxxxxx->6, 1xxxxxxx->7
  - valid=1 for every step; out never X.
- Zero input: en=1, in=8'h00 -> out=0, valid=0, multi=0.
- Multi-hot with known inputs: in=8'b10000001 -> out=7, multi=1. in=8'b00100000 -> out=5, multi=0. in=8'b01010100 -> out=6, multi=1.
- Hold mode (HOLD_WHEN_DISABLED=1): encode in=8'b00010000 (out=4, valid=1), then en=0 with in=8'h80 for 3 cycles -> out stays 4, valid stays 1. Re-enable -> out=7 one edge later.

Source files
------------

// File: rtl/priority_encoder_8x3_if.sv
// Request/result bundle for the 8-to-3 priority encoder.
// Master drives the enable and request vector; slave returns the registered index and flags.
interface priority_encoder_8x3_if;
  logic       en;
  logic [7:0] in;
  logic [2:0] out;
  logic       valid;
  logic       multi;

  modport master (
    output en,
    output in,
    input  out,
    input  valid,
    input  multi
  );

  modport slave (
    input  en,
    input  in,
    output out,
    output valid,
    output multi
  );
endinterface

// File: rtl/priority_encoder_8x3.sv
// Registered 8-to-3 priority encoder: bit 7 wins, with valid and multi-hot flags.
// One clock of latency; while disabled the outputs either clear or hold, per HOLD_WHEN_DISABLED.
module priority_encoder_8x3 #(
  parameter int HOLD_WHEN_DISABLED = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  priority_encoder_8x3_if.slave        encBus
);

  logic [2:0] encIdx_d;
  logic       encValid_d;
  logic       encMulti_d;

  logic [2:0] encIdx_q;
  logic       encValid_q;
  logic       encMulti_q;

  // casez wildcards keep unknown bits below the leading one from reaching index or valid.
  always_comb begin
    encIdx_d   = 3'd0;
    encValid_d = 1'b1;
    casez (encBus.in)
      8'b1???????: encIdx_d = 3'd7;
      8'b01??????: encIdx_d = 3'd6;
      8'b001?????: encIdx_d = 3'd5;
      8'b0001????: encIdx_d = 3'd4;
      8'b00001???: encIdx_d = 3'd3;
      8'b000001??: encIdx_d = 3'd2;
      8'b0000001?: encIdx_d = 3'd1;
      8'b00000001: encIdx_d = 3'd0;
      default: begin
        encIdx_d   = 3'd0;
        encValid_d = 1'b0;
      end
    endcase
    encMulti_d = |(encBus.in & (encBus.in - 8'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      encIdx_q   <= 3'd0;
      encValid_q <= 1'b0;
      encMulti_q <= 1'b0;
    end else if (encBus.en) begin
      encIdx_q   <= encIdx_d;
      encValid_q <= encValid_d;
      encMulti_q <= encMulti_d;
    end else if (HOLD_WHEN_DISABLED == 0) begin
      encIdx_q   <= 3'd0;
      encValid_q <= 1'b0;
      encMulti_q <= 1'b0;
    end
  end

  assign encBus.out   = encIdx_q;
  assign encBus.valid = encValid_q;
  assign encBus.multi = encMulti_q;

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Self-checking bench for priority_encoder_8x3: clearing and holding variants run side by side
// from a shared stimulus table, hand-written corner sequences and random vectors.
module tb_priority_encoder_8x3;

  typedef struct {
    logic       en;
    logic [7:0] vin;
    logic [2:0] expOut;
    logic       expValid;
    logic       expMulti;
    logic       chkMulti;
    string      tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] holdOut;
  logic       holdValid;
  logic       holdMulti;
  logic [2:0] clrOut;
  logic       clrValid;
  logic       clrMulti;

  vec_t tbl[14];

  priority_encoder_8x3_if ifClr ();
  priority_encoder_8x3_if ifHold ();

  priority_encoder_8x3 #(.HOLD_WHEN_DISABLED(0)) dutClr (
    .clk    (clk),
    .rst_n  (rst_n),
    .encBus (ifClr.slave)
  );

  priority_encoder_8x3 #(.HOLD_WHEN_DISABLED(1)) dutHold (
    .clk    (clk),
    .rst_n  (rst_n),
    .encBus (ifHold.slave)
  );

  always #5 clk = ~clk;

  // Reference: leading one found by scanning upward, multi-hot by counting ones.
  function automatic void refEncode(input logic [7:0] v, output logic [2:0] idx,
                                    output logic vld, output logic mh);
    int ones;
    ones = 0;
    idx  = 3'd0;
    vld  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] === 1'b1) begin
        ones++;
        idx = i[2:0];
        vld = 1'b1;
      end
    end
    mh = (ones > 1);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive both DUTs away from the edge, clock once, then advance the behavioural models.
  task automatic applyStimulus(input logic en, input logic [7:0] v);
    logic [2:0] idx;
    logic       vld;
    logic       mh;
    @(negedge clk);
    ifClr.en  = en;
    ifClr.in  = v;
    ifHold.en = en;
    ifHold.in = v;
    @(posedge clk);
    #1;
    refEncode(v, idx, vld, mh);
    if (!rst_n) begin
      {clrOut, clrValid, clrMulti}    = 5'd0;
      {holdOut, holdValid, holdMulti} = 5'd0;
    end else if (en) begin
      {clrOut, clrValid, clrMulti}    = {idx, vld, mh};
      {holdOut, holdValid, holdMulti} = {idx, vld, mh};
    end else begin
      {clrOut, clrValid, clrMulti}    = 5'd0;
    end
  endtask

  task automatic checkBoth(input string tag, input logic [2:0] eOut, input logic eValid,
                           input logic eMulti, input logic chkMulti);
    checkOutput({tag, " clr.out"},   {5'd0, ifClr.out},   {5'd0, eOut});
    checkOutput({tag, " clr.valid"}, {7'd0, ifClr.valid}, {7'd0, eValid});
    checkOutput({tag, " hold.out"},   {5'd0, ifHold.out},   {5'd0, holdOut});
    checkOutput({tag, " hold.valid"}, {7'd0, ifHold.valid}, {7'd0, holdValid});
    if (chkMulti) begin
      checkOutput({tag, " clr.multi"},  {7'd0, ifClr.multi},  {7'd0, eMulti});
      checkOutput({tag, " hold.multi"}, {7'd0, ifHold.multi}, {7'd0, holdMulti});
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'b00000001, 3'd0, 1'b0, 1'b0, 1'b1, "disabled"};
    tbl[1]  = '{1'b1, 8'b00000001, 3'd0, 1'b1, 1'b0, 1'b1, "reenable"};
    tbl[2]  = '{1'b1, 8'b0000001x, 3'd1, 1'b1, 1'b0, 1'b0, "walk1"};
    tbl[3]  = '{1'b1, 8'b000001xx, 3'd2, 1'b1, 1'b0, 1'b0, "walk2"};
    tbl[4]  = '{1'b1, 8'b00001xxx, 3'd3, 1'b1, 1'b0, 1'b0, "walk3"};
    tbl[5]  = '{1'b1, 8'b0001xxxx, 3'd4, 1'b1, 1'b0, 1'b0, "walk4"};
    tbl[6]  = '{1'b1, 8'b001xxxxx, 3'd5, 1'b1, 1'b0, 1'b0, "walk5"};
    tbl[7]  = '{1'b1, 8'b01xxxxxx, 3'd6, 1'b1, 1'b0, 1'b0, "walk6"};
    tbl[8]  = '{1'b1, 8'b1xxxxxxx, 3'd7, 1'b1, 1'b0, 1'b0, "walk7"};
    tbl[9]  = '{1'b1, 8'h00,       3'd0, 1'b0, 1'b0, 1'b1, "zero"};
    tbl[10] = '{1'b1, 8'b10000001, 3'd7, 1'b1, 1'b1, 1'b1, "multi81"};
    tbl[11] = '{1'b1, 8'b00100000, 3'd5, 1'b1, 1'b0, 1'b1, "single20"};
    tbl[12] = '{1'b1, 8'b01010100, 3'd6, 1'b1, 1'b1, 1'b1, "multi54"};
    tbl[13] = '{1'b1, 8'b11111111, 3'd7, 1'b1, 1'b1, 1'b1, "allones"};

    rst_n = 1'b0;
    {ifClr.en, ifClr.in, ifHold.en, ifHold.in} = '0;
    {clrOut, clrValid, clrMulti, holdOut, holdValid, holdMulti} = '0;

    // Reset dominates a fully asserted request, then releases into a valid encode.
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFF);
    checkBoth("reset", 3'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'hFF);
    checkBoth("release", 3'd7, 1'b1, 1'b1, 1'b1);

    foreach (tbl[k]) begin
      applyStimulus(tbl[k].en, tbl[k].vin);
      checkBoth(tbl[k].tag, tbl[k].expOut, tbl[k].expValid, tbl[k].expMulti, tbl[k].chkMulti);
    end

    // Hold-mode sequence with hand-written expectations for the holding DUT.
    applyStimulus(1'b1, 8'b00010000);
    checkOutput("holdSeq load out", {5'd0, ifHold.out}, 8'd4);
    checkOutput("holdSeq load valid", {7'd0, ifHold.valid}, 8'd1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 8'h80);
      checkOutput("holdSeq idle out", {5'd0, ifHold.out}, 8'd4);
      checkOutput("holdSeq idle valid", {7'd0, ifHold.valid}, 8'd1);
      checkOutput("holdSeq idle multi", {7'd0, ifHold.multi}, 8'd0);
      checkOutput("holdSeq clr out", {5'd0, ifClr.out}, 8'd0);
      checkOutput("holdSeq clr valid", {7'd0, ifClr.valid}, 8'd0);
    end
    applyStimulus(1'b1, 8'h80);
    checkOutput("holdSeq reenable out", {5'd0, ifHold.out}, 8'd7);
    checkOutput("holdSeq reenable valid", {7'd0, ifHold.valid}, 8'd1);
    checkOutput("holdSeq reenable clr out", {5'd0, ifClr.out}, 8'd7);

    for (int r = 0; r < 300; r++) begin
      logic       rEn;
      logic [7:0] rIn;
      rEn = ($urandom_range(0, 3) != 0);
      rIn = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        rIn = 8'd1 << $urandom_range(0, 7);
      applyStimulus(rEn, rIn);
      checkBoth("random", clrOut, clrValid, clrMulti, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
